// File: rtl/yags_table_arbiter.sv
// Shares one single-port YAGS table between fetch lookups and queued EX updates; clears it after reset.
// Latency: lookup data 1 cycle after grant; updates drain in idle slots, forced out when the queue is full.
// Backpressure: lk_ready/up_ready low during the clear sweep; up_ready low when full. YAGS_ARB_STATS_EN adds counters.
module yags_table_arbiter #(
  parameter int                ENTRIES  = 1024,
  parameter int                IDX_W    = $clog2(ENTRIES),
  parameter int                DATA_W   = 2,
  parameter int                UQ_DEPTH = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lk_valid,
  input  logic [IDX_W-1:0]  lk_index,
  output logic              lk_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              up_valid,
  input  logic [IDX_W-1:0]  up_index,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [IDX_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_done
`ifdef YAGS_ARB_STATS_EN
  ,
  output logic [31:0]       stat_lk_stall,
  output logic [31:0]       stat_up_full
`endif
);

  localparam int PTR_W = $clog2(UQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ctr_q, ctr_d;
  logic                init_done_q, init_done_d;
  logic                rd_valid_q, rd_valid_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    uq_idx_q [UQ_DEPTH];
  logic [IDX_W-1:0]    uq_idx_d [UQ_DEPTH];
  logic [DATA_W-1:0]   uq_dat_q [UQ_DEPTH];
  logic [DATA_W-1:0]   uq_dat_d [UQ_DEPTH];

  logic sweep_last;
  logic uq_full;
  logic push;
  logic pop;

  assign sweep_last = (state_q == ST_INIT) && (ctr_q == IDX_W'(ENTRIES - 1));
  assign uq_full    = (count_q == CNT_W'(UQ_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sweep_last) begin
      state_d = ST_RUN;
    end
  end

  // Outputs are held at zero while reset is asserted, even though state sits in INIT.
  always_comb begin
    lk_ready  = 1'b0;
    up_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pop       = 1'b0;
    if (reset) begin
      case (state_q)
        ST_INIT: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ctr_q;
          mem_wdata = INIT_VAL;
        end
        default: begin
          up_ready = !uq_full;
          if (uq_full) begin
            pop = 1'b1;
          end else if (lk_valid) begin
            lk_ready = 1'b1;
            mem_en   = 1'b1;
            mem_addr = lk_index;
          end else if (count_q != '0) begin
            pop = 1'b1;
          end
          if (pop) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = uq_idx_q[rd_ptr_q];
            mem_wdata = uq_dat_q[rd_ptr_q];
          end
        end
      endcase
    end
    push = up_valid && up_ready;
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_valid_q ? mem_rdata : '0;
  assign init_done = init_done_q;

  // up_ready comes from the registered count, so a pop never opens a slot for a same-cycle push.
  always_comb begin
    ctr_d       = ctr_q;
    init_done_d = init_done_q | sweep_last;
    rd_valid_d  = lk_ready;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    uq_idx_d    = uq_idx_q;
    uq_dat_d    = uq_dat_q;
    if (state_q == ST_INIT) begin
      ctr_d = ctr_q + IDX_W'(1);
    end
    if (push) begin
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      uq_idx_d[wr_ptr_q] = up_index;
      uq_dat_d[wr_ptr_q] = up_data;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctr_q       <= '0;
      init_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < UQ_DEPTH; i++) begin
        uq_idx_q[i] <= '0;
        uq_dat_q[i] <= '0;
      end
    end else begin
      ctr_q       <= ctr_d;
      init_done_q <= init_done_d;
      rd_valid_q  <= rd_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      uq_idx_q    <= uq_idx_d;
      uq_dat_q    <= uq_dat_d;
    end
  end

`ifdef YAGS_ARB_STATS_EN
  logic [31:0] stat_lk_stall_q, stat_lk_stall_d;
  logic [31:0] stat_up_full_q, stat_up_full_d;

  always_comb begin
    stat_lk_stall_d = stat_lk_stall_q;
    stat_up_full_d  = stat_up_full_q;
    if ((state_q == ST_RUN) && lk_valid && !lk_ready && (stat_lk_stall_q != 32'hFFFF_FFFF)) begin
      stat_lk_stall_d = stat_lk_stall_q + 32'd1;
    end
    if (up_valid && !up_ready && (stat_up_full_q != 32'hFFFF_FFFF)) begin
      stat_up_full_d = stat_up_full_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_lk_stall_q <= '0;
      stat_up_full_q  <= '0;
    end else begin
      stat_lk_stall_q <= stat_lk_stall_d;
      stat_up_full_q  <= stat_up_full_d;
    end
  end

  assign stat_lk_stall = stat_lk_stall_q;
  assign stat_up_full  = stat_up_full_q;
`endif

endmodule

// File: tb/tb_yags_table_arbiter.sv
// Bench for yags_table_arbiter at ENTRIES=16: directed stimulus, expected RAM writes and
// lookup data queued at issue time and compared by an independent negedge monitor.
module tb_yags_table_arbiter;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int DATA_W  = 2;

  logic              clk;
  logic              reset;
  logic              lk_valid;
  logic [IDX_W-1:0]  lk_index;
  logic              lk_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              up_valid;
  logic [IDX_W-1:0]  up_index;
  logic [DATA_W-1:0] up_data;
  logic              up_ready;
  logic              mem_en;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              init_done;
`ifdef YAGS_ARB_STATS_EN
  logic [31:0]       stat_lk_stall;
  logic [31:0]       stat_up_full;
`endif

  yags_table_arbiter #(.ENTRIES(ENTRIES), .DATA_W(DATA_W), .UQ_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .lk_valid  (lk_valid),
    .lk_index  (lk_index),
    .lk_ready  (lk_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .up_valid  (up_valid),
    .up_index  (up_index),
    .up_data   (up_data),
    .up_ready  (up_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .init_done (init_done)
`ifdef YAGS_ARB_STATS_EN
    ,
    .stat_lk_stall (stat_lk_stall),
    .stat_up_full  (stat_up_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM standing in for the predictor table.
  logic [DATA_W-1:0] ram [ENTRIES];
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [IDX_W+DATA_W-1:0] exp_wr [$];
  logic [DATA_W-1:0]       exp_rd [$];
  logic [IDX_W+DATA_W-1:0] wr_e;
  logic [DATA_W-1:0]       rd_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_write(input int addr, input int data);
    exp_wr.push_back({IDX_W'(addr), DATA_W'(data)});
  endtask

  // Monitor: every RAM write and every lookup response is matched against the scoreboard.
  always @(negedge clk) begin
    if (mem_en && mem_we) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d, required no write", mem_addr, mem_wdata);
      end else begin
        wr_e = exp_wr.pop_front();
        check("ram_write", 32'({mem_addr, mem_wdata}), 32'(wr_e));
      end
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got data %0d, required no response", rd_data);
      end else begin
        rd_e = exp_rd.pop_front();
        check("rd_data", 32'(rd_data), 32'(rd_e));
      end
    end else begin
      check("rd_data_idle", 32'(rd_data), 32'd0);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, required finish before 20000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; lk_valid = 1'b0; lk_index = '0;
    up_valid = 1'b0; up_index = '0; up_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_lk_ready",  32'(lk_ready),  32'd0);
    check("rst_up_ready",  32'(up_ready),  32'd0);
    check("rst_rd_valid",  32'(rd_valid),  32'd0);

    // Clear sweep: 16 writes of 2'b01 at addr 0..15, requests refused throughout
    for (int i = 0; i < ENTRIES; i++) exp_write(i, 1);
    tick;
    reset = 1'b1; lk_valid = 1'b1; lk_index = 4'd0;
    up_valid = 1'b1; up_index = 4'd2; up_data = 2'b11;
    for (int i = 0; i < ENTRIES; i++) begin
      @(negedge clk);
      check("init_lk_ready", 32'(lk_ready), 32'd0);
      check("init_up_ready", 32'(up_ready), 32'd0);
      check("init_done_low", 32'(init_done), 32'd0);
      tick;
      if (i == 2)  up_valid = 1'b0;
      if (i == 15) lk_valid = 1'b0;
    end
    @(negedge clk);
    check("init_done_high", 32'(init_done), 32'd1);
    check("run_idle_en",    32'(mem_en),    32'd0);

    // Single update into an empty queue drains on the next idle cycle
    tick;
    up_valid = 1'b1; up_index = 4'd9; up_data = 2'b00;
    exp_write(9, 0);
    @(negedge clk);
    check("push9_up_ready", 32'(up_ready), 32'd1);
    check("push9_no_mem",   32'(mem_en),   32'd0);
    tick;
    up_valid = 1'b0;
    @(negedge clk);
    check("drain9_we", 32'(mem_we), 32'd1);
    tick;
    @(negedge clk);
    check("drain9_empty", 32'(mem_en), 32'd0);

    // Put 2'b11 at idx 5, then look it up
    tick;
    up_valid = 1'b1; up_index = 4'd5; up_data = 2'b11;
    exp_write(5, 3);
    @(negedge clk);
    tick;
    up_valid = 1'b0;
    @(negedge clk);
    tick;
    @(negedge clk);
    check("drain5_empty", 32'(mem_en), 32'd0);
    tick;
    lk_valid = 1'b1; lk_index = 4'd5;
    @(negedge clk);
    check("lk5_ready", 32'(lk_ready), 32'd1);
    check("lk5_en",    32'(mem_en),   32'd1);
    check("lk5_we",    32'(mem_we),   32'd0);
    check("lk5_addr",  32'(mem_addr), 32'd5);
    exp_rd.push_back(2'b11);
    tick;
    lk_valid = 1'b0;
    @(negedge clk);
    check("lk5_rd_valid", 32'(rd_valid), 32'd1);

    // Lookups held high while four updates fill the queue
    tick;
    lk_valid = 1'b1; lk_index = 4'd1;
    up_valid = 1'b1; up_index = 4'd3; up_data = 2'b10;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("fill_lk_ready", 32'(lk_ready), 32'd1);
      check("fill_up_ready", 32'(up_ready), 32'd1);
      exp_rd.push_back(2'b01);
      exp_write(3 + j, 2);
      tick;
      if (j < 3) up_index = IDX_W'(4 + j);
      else begin
        up_valid = 1'b0;
        lk_index = 4'd5;
      end
    end
    @(negedge clk);
    check("full_up_ready", 32'(up_ready), 32'd0);
    check("full_lk_ready", 32'(lk_ready), 32'd0);
    check("full_we",       32'(mem_we),   32'd1);
    check("full_addr",     32'(mem_addr), 32'd3);
    tick;
    up_valid = 1'b1; up_index = 4'd7; up_data = 2'b11;
    exp_write(7, 3);
    @(negedge clk);
    check("after_full_lk_ready", 32'(lk_ready), 32'd1);
    check("after_full_up_ready", 32'(up_ready), 32'd1);
    check("after_full_we",       32'(mem_we),   32'd0);
    // idx 5 still has a queued update to 2'b10: the lookup must see the old 2'b11
    exp_rd.push_back(2'b11);
    tick;
    up_valid = 1'b0;
    @(negedge clk);
    check("refull_lk_ready", 32'(lk_ready), 32'd0);
    check("refull_up_ready", 32'(up_ready), 32'd0);
    tick;
    lk_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tick;
    end
    @(negedge clk);
    check("drained_idle", 32'(mem_en), 32'd0);
`ifdef YAGS_ARB_STATS_EN
    check("stat_lk_stall", stat_lk_stall, 32'd2);
    check("stat_up_full",  stat_up_full,  32'd3);
`endif

    // Reset with three updates queued behind held lookups
    tick;
    lk_valid = 1'b1; lk_index = 4'd1;
    up_valid = 1'b1; up_index = 4'd10; up_data = 2'b11;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("q3_lk_ready", 32'(lk_ready), 32'd1);
      if (j < 2) exp_rd.push_back(2'b01);
      tick;
      if (j < 2) up_index = IDX_W'(11 + j);
      else begin
        up_valid = 1'b0;
        lk_valid = 1'b0;
        reset    = 1'b0;
      end
    end
    @(negedge clk);
    check("rst2_rd_valid",  32'(rd_valid),  32'd0);
    check("rst2_mem_en",    32'(mem_en),    32'd0);
    check("rst2_init_done", 32'(init_done), 32'd0);
    check("rst2_up_ready",  32'(up_ready),  32'd0);
`ifdef YAGS_ARB_STATS_EN
    check("rst2_stat_lk_stall", stat_lk_stall, 32'd0);
    check("rst2_stat_up_full",  stat_up_full,  32'd0);
`endif
    for (int i = 0; i < ENTRIES; i++) exp_write(i, 1);
    tick;
    reset = 1'b1;
    repeat (ENTRIES) begin
      @(negedge clk);
      tick;
    end
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle",      32'(mem_en),    32'd0);
      check("post_rst_init_done", 32'(init_done), 32'd1);
      check("post_rst_up_ready",  32'(up_ready),  32'd1);
      tick;
    end

    check("exp_wr_left", 32'(exp_wr.size()), 32'd0);
    check("exp_rd_left", 32'(exp_rd.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
